// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings, port ids and defaults for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts stalled BUSY cycles and flags the cycle that reaches TIMEOUT
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT + 1);
      logic [W-1:0] cnt;
      always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt <= '0;
        else if (i_clear) cnt <= '0;
        else if (i_run) cnt <= cnt + 1'b1;
      // Fires on the TIMEOUT-th stalled cycle, so o_mem_req stays high exactly TIMEOUT cycles
      assign o_expired = i_run && (cnt == W'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU fetch and data ports with req/ack and a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise data always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_i_req,
  input  logic [ADDR_W-1:0]   i_i_addr,
  output logic                o_i_ack,
  output logic [DATA_W-1:0]   o_i_rdata,
  output logic                o_i_err,
  input  logic                i_d_req,
  input  logic                i_d_wr,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic                o_d_ack,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_err,
  output logic                o_mem_req,
  output logic                o_mem_wr,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_ready
);
  state_t state;
  logic   port;
  logic   expired;
  logic   pick_d;
`ifdef ARB_ROUND_ROBIN_EN
  // port doubles as the last-grant register: it resets to I and updates on every grant
  assign pick_d = i_d_req && (!i_i_req || port == PORT_I);
`else
  assign pick_d = i_d_req;
`endif
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (state == BUSY && !i_mem_ready),
    .i_clear  (state != BUSY),
    .o_expired(expired)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state       <= IDLE;
      port        <= PORT_I;
      o_i_ack     <= 1'b0;
      o_i_rdata   <= '0;
      o_i_err     <= 1'b0;
      o_d_ack     <= 1'b0;
      o_d_rdata   <= '0;
      o_d_err     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else begin
      o_i_ack <= 1'b0;
      o_i_err <= 1'b0;
      o_d_ack <= 1'b0;
      o_d_err <= 1'b0;
      case (state)
        IDLE: if (i_d_req || i_i_req) begin
          port        <= pick_d ? PORT_D : PORT_I;
          o_mem_req   <= 1'b1;
          o_mem_wr    <= pick_d && i_d_wr;
          o_mem_addr  <= pick_d ? i_d_addr : i_i_addr;
          o_mem_wdata <= pick_d ? i_d_wdata : '0;
          o_mem_be    <= (pick_d && i_d_wr) ? i_d_be : '1;
          state       <= BUSY;
        end
        BUSY: if (i_mem_ready || expired) begin
          o_mem_req <= 1'b0;
          state     <= DONE;
          if (port == PORT_D) begin
            o_d_ack <= 1'b1;
            o_d_err <= !i_mem_ready;
            if (i_mem_ready && !o_mem_wr) o_d_rdata <= i_mem_rdata;
          end else begin
            o_i_ack <= 1'b1;
            o_i_err <= !i_mem_ready;
            if (i_mem_ready) o_i_rdata <= i_mem_rdata;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a reactive wait-state memory model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [137:0] outs;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic mem_en = 1'b1;
  int mem_wait = 0;
  int wcnt = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  typedef struct {logic [31:0] rdata; logic err; int ack;} exp_t;
  exp_t iq[$];
  exp_t dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_rdata(i_rdata), .o_i_err(i_err),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_be(mem_be), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  assign outs = {i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_req, mem_wr, mem_addr, mem_wdata, mem_be};

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h8) ? 32'h00108093 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory answers after mem_wait stalled cycles; never answers while mem_en is low
  always @(negedge clk) begin
    if (mem_ready || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_en) begin
      if (wcnt == mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = mem_data(mem_addr);
      end else wcnt++;
    end
  end

  task automatic access(input logic port, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic terr, input int dly, input int nreq);
    exp_t e, g;
    int reqs = 0;
    bit got = 0;
    logic ack;
    logic [3:0] ebe = (port && wr) ? be : 4'hf;
    e.err = terr;
    e.ack = cyc + dly;
    if (port) begin
      e.rdata = (wr || terr) ? last_d : mem_data(addr);
      last_d = e.rdata;
      dq.push_back(e);
      d_wr = wr; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    end else begin
      e.rdata = terr ? last_i : mem_data(addr);
      last_i = e.rdata;
      iq.push_back(e);
      i_addr = addr; i_req = 1'b1;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == addr) begin
        reqs++;
        checks++;
        if (mem_wr !== (port & wr) || mem_be !== ebe || (port && mem_wdata !== wdata)) begin
          errors++;
          $display("FAIL mem_fields addr=%h: wr=%b be=%b wdata=%h, required wr=%b be=%b wdata=%h",
                   addr, mem_wr, mem_be, mem_wdata, port & wr, ebe, wdata);
        end
      end
      ack = port ? d_ack : i_ack;
      if (ack) begin
        got = 1;
        if (port) g = dq.pop_front(); else g = iq.pop_front();
        checks += 3;
        if ((port ? d_rdata : i_rdata) !== g.rdata) begin
          errors++;
          $display("FAIL rdata port=%b addr=%h: got %h, required %h", port, addr, port ? d_rdata : i_rdata, g.rdata);
        end
        if ((port ? d_err : i_err) !== g.err) begin
          errors++;
          $display("FAIL err port=%b addr=%h: got %b, required %b", port, addr, port ? d_err : i_err, g.err);
        end
        if (cyc != g.ack) begin
          errors++;
          $display("FAIL ack_cycle port=%b addr=%h: got %0d, required %0d", port, addr, cyc, g.ack);
        end
        if (port) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port=%b addr=%h: got no ack, required ack", port, addr);
      if (port) d_req = 1'b0; else i_req = 1'b0;
    end
    checks++;
    if (reqs != nreq) begin
      errors++;
      $display("FAIL mem_req_cycles addr=%h: got %0d, required %0d", addr, reqs, nreq);
    end
    @(negedge clk);
    checks++;
    if ((port ? {d_ack, d_err} : {i_ack, i_err}) !== 2'b00) begin
      errors++;
      $display("FAIL ack_pulse port=%b: ack/err still high after ack cycle, required 00", port);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    mem_wait = 0;
    @(negedge clk);
    access(1'b0, 1'b0, 32'h8, '0, '0, 1'b0, 2, 1);
  endtask

  task automatic test_contention;
    mem_wait = 0;
    fork
      access(1'b1, 1'b0, 32'h100, '0, '0, 1'b0, 2, 1);
      access(1'b0, 1'b0, 32'h200, '0, '0, 1'b0, 5, 1);
    join
  endtask

  task automatic test_write;
    mem_wait = 2;
    access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b0, 4, 3);
  endtask

  task automatic test_contention2;
    mem_wait = 0;
`ifdef ARB_ROUND_ROBIN_EN
    fork
      access(1'b1, 1'b0, 32'h104, '0, '0, 1'b0, 5, 1);
      access(1'b0, 1'b0, 32'h204, '0, '0, 1'b0, 2, 1);
    join
`else
    fork
      access(1'b1, 1'b0, 32'h104, '0, '0, 1'b0, 2, 1);
      access(1'b0, 1'b0, 32'h204, '0, '0, 1'b0, 5, 1);
    join
`endif
  endtask

  task automatic test_timeout;
    mem_en = 1'b0;
    access(1'b1, 1'b0, 32'h80, '0, '0, 1'b1, 5, 4);
    mem_en = 1'b1;
  endtask

  task automatic test_ready_at_timeout;
    mem_wait = 3;
    access(1'b1, 1'b0, 32'h84, '0, '0, 1'b0, 5, 4);
  endtask

  task automatic test_reset_busy;
    mem_en = 1'b0;
    d_wr = 1'b0; d_addr = 32'h88; d_be = 4'hf; d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: mem_req %b, required 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, required 0", outs);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (d_ack !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL ack_during_reset: ack=%b mem_req=%b, required 0 0", d_ack, mem_req);
      end
    end
    rst = 1'b0;
    mem_en = 1'b1;
    mem_wait = 0;
    last_i = '0;
    last_d = '0;
    access(1'b1, 1'b0, 32'h88, '0, 4'hf, 1'b0, 2, 1);
  endtask

  initial begin
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset;
    test_fetch;
    test_contention;
    test_write;
    test_contention2;
    test_timeout;
    test_ready_at_timeout;
    test_reset_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end
endmodule
